// File: rtl/pkg_74xx.sv
// Shared constants for the 74xx-style counter family.
// Level encodings, direction codes and default modulus.
package pkg_74xx;

  localparam logic ACT_LO_ON  = 1'b0;
  localparam logic ACT_LO_OFF = 1'b1;

  localparam logic UD_UP   = 1'b1;
  localparam logic UD_DOWN = 1'b0;

  function automatic int default_modulus(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/mod_74x169_n_tc.sv
// Terminal-count and next-step decode for the 74x169 counter.
// Purely combinational; arithmetic held to WIDTH+1 bits.
module mod_74x169_tc
  import pkg_74xx::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic             ud,
  output logic             tc,
  output logic [WIDTH-1:0] q_step
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_Q = MAX_EXT[WIDTH-1:0];

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] q_inc;
  logic           at_max;
  logic           at_zero;
  logic           below_max;

  always_comb begin
    q_ext     = {1'b0, q};
    q_inc     = q_ext + (WIDTH+1)'(1);
    at_max    = (q_ext == MAX_EXT);
    at_zero   = (q == '0);
    below_max = (q_ext < MAX_EXT);
    tc        = (ud == UD_UP) ? at_max : at_zero;
    q_step    = q;
    if (ud == UD_UP) begin
      // anything at or past the top wraps straight to 0
      q_step = below_max ? q_inc[WIDTH-1:0] : '0;
    end else begin
      q_step = at_zero ? MAX_Q : (q - WIDTH'(1));
    end
  end

endmodule

// File: rtl/mod_74x169_n.sv
// Synchronous presettable up/down modulo counter (74x169 style).
// Q register, load/count/hold priority mux and RCO_N gate.
module mod_74x169_n
  import pkg_74xx::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = default_modulus(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LD_N,
  input  logic             ENP_N,
  input  logic             ENT_N,
  input  logic             UD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO_N
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("mod_74x169_n: WIDTH must be in 2..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
    $error("mod_74x169_n: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_step;
  logic             tc;

  mod_74x169_tc #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc (
    .q      (q_q),
    .ud     (UD),
    .tc     (tc),
    .q_step (q_step)
  );

  always_comb begin
    q_d = q_q;
    priority case (1'b1)
      (LD_N == ACT_LO_ON): q_d = D;
      (ENP_N == ACT_LO_ON && ENT_N == ACT_LO_ON): q_d = q_step;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) q_q <= '0;
    else     q_q <= q_d;
  end

  assign Q     = q_q;
  assign RCO_N = (ENT_N == ACT_LO_ON && tc) ? ACT_LO_ON : ACT_LO_OFF;

endmodule

// File: tb/tb_mod_74x169_n.sv
// Directed bench for mod_74x169_n with a per-cycle reference model.
// Includes a two-stage cascade of modulo-16 counters.
module tb_mod_74x169_n;

  localparam int M = 10;

  logic       CLK = 1'b0;
  logic       RST, LD_N, ENP_N, ENT_N, UD;
  logic [3:0] D;
  logic [3:0] Q;
  logic       RCO_N;

  logic       c_rst;
  logic       lo_rco, hi_rco;
  logic [3:0] lo_q, hi_q;

  int checks   = 0;
  int failures = 0;
  int mq       = 0;
  bit chk_en   = 1'b0;

  always #5 CLK = ~CLK;

  mod_74x169_n #(.WIDTH(4), .MODULUS(M)) dut (
    .CLK(CLK), .RST(RST), .LD_N(LD_N), .ENP_N(ENP_N),
    .ENT_N(ENT_N), .UD(UD), .D(D), .Q(Q), .RCO_N(RCO_N)
  );

  mod_74x169_n #(.WIDTH(4), .MODULUS(16)) u_lo (
    .CLK(CLK), .RST(c_rst), .LD_N(1'b1), .ENP_N(1'b0),
    .ENT_N(1'b0), .UD(1'b1), .D(4'd0), .Q(lo_q), .RCO_N(lo_rco)
  );

  mod_74x169_n #(.WIDTH(4), .MODULUS(16)) u_hi (
    .CLK(CLK), .RST(c_rst), .LD_N(1'b1), .ENP_N(1'b0),
    .ENT_N(lo_rco), .UD(1'b1), .D(4'd0), .Q(hi_q), .RCO_N(hi_rco)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: reset, load, count, hold
  always @(posedge CLK) begin
    if (RST) mq <= 0;
    else if (!LD_N) mq <= int'(D);
    else if (!ENP_N && !ENT_N) begin
      if (UD) mq <= (mq >= M - 1) ? 0 : mq + 1;
      else    mq <= (mq == 0) ? M - 1 : mq - 1;
    end
  end

  function automatic int exp_rco();
    bit tc;
    tc = UD ? (mq == M - 1) : (mq == 0);
    return (!ENT_N && tc) ? 0 : 1;
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_q", int'(Q), mq);
      chk("model_rco", int'(RCO_N), exp_rco());
    end
  end

  task automatic drive(input logic rst, input logic ld_n, input logic enp_n,
                       input logic ent_n, input logic ud, input logic [3:0] d);
    RST = rst; LD_N = ld_n; ENP_N = enp_n; ENT_N = ent_n; UD = ud; D = d;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  int up_seq[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
  int dn_seq[5]  = '{2, 1, 0, 9, 8};

  initial begin
    c_rst = 1'b1;
    drive(1, 1, 1, 1, 1, 0);
    tick();
    chk_en = 1'b1;
    chk("reset_q", int'(Q), 0);
    chk("reset_rco_up", int'(RCO_N), 1);
    drive(1, 1, 1, 0, 0, 0);
    #1;
    chk("reset_rco_down", int'(RCO_N), 0);
    tick();

    // up wrap
    drive(0, 1, 0, 0, 1, 0);
    #1;
    for (int i = 0; i < 12; i++) begin
      chk("up_q", int'(Q), up_seq[i]);
      chk("up_rco", int'(RCO_N), (up_seq[i] == 9) ? 0 : 1);
      tick();
    end

    // down wrap
    drive(0, 0, 1, 1, 0, 4'd2);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("dn_q", int'(Q), dn_seq[i]);
      chk("dn_rco", int'(RCO_N), (dn_seq[i] == 0) ? 0 : 1);
      tick();
    end

    // load to top with ENT_N low: RCO_N right after load
    drive(0, 0, 1, 0, 1, 4'd9);
    tick();
    chk("load9_q", int'(Q), 9);
    chk("load9_rco", int'(RCO_N), 0);

    // enable gating
    drive(0, 1, 1, 0, 1, 0);
    tick();
    chk("hold_q", int'(Q), 9);
    chk("hold_rco", int'(RCO_N), 0);
    ENT_N = 1'b1;
    #1;
    chk("ent_rco_comb", int'(RCO_N), 1);
    tick();
    chk("hold2_q", int'(Q), 9);

    // reset beats load
    drive(1, 0, 0, 0, 1, 4'd5);
    tick();
    chk("prio_rst_q", int'(Q), 0);
    drive(0, 0, 0, 0, 1, 4'd5);
    tick();
    chk("prio_ld_q", int'(Q), 5);

    // out of range, up
    drive(0, 0, 1, 1, 1, 4'd13);
    tick();
    chk("oor_load_q", int'(Q), 13);
    drive(0, 1, 0, 0, 1, 0);
    #1;
    chk("oor_up_rco", int'(RCO_N), 1);
    tick();
    chk("oor_up_q", int'(Q), 0);

    // out of range, down
    drive(0, 0, 1, 1, 0, 4'd13);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    tick();
    chk("oor_dn_q", int'(Q), 12);

    // reset mid-count, then resume from 0
    drive(0, 0, 1, 1, 1, 4'd3);
    tick();
    drive(0, 1, 0, 0, 1, 0);
    tick();
    chk("mid_q", int'(Q), 4);
    RST = 1'b1;
    tick();
    chk("mid_rst_q", int'(Q), 0);
    RST = 1'b0;
    tick();
    chk("resume_q", int'(Q), 1);

    // direction change takes effect at once
    UD = 1'b0;
    tick();
    chk("ud_flip_q", int'(Q), 0);
    tick();
    chk("ud_wrap_q", int'(Q), 9);

    // cascade of two modulo-16 stages
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) begin
      chk("casc_val", int'({hi_q, lo_q}), i);
      chk("casc_rco", int'(hi_rco), (i == 255) ? 0 : 1);
      tick();
    end
    chk("casc_wrap", int'({hi_q, lo_q}), 0);
    chk("casc_wrap_rco", int'(hi_rco), 1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_74x169_n.md
MOD_74X169_N -- requirements
Module: mod_74x169_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter bit width (legal range 2..16).
REQ-002 The block SHALL have parameter MODULUS, default 2**WIDTH, count length (legal range 2..2**WIDTH).
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 LD_N  input  1  parallel load, active-low.
REQ-006 ENP_N  input  1  count enable P, active-low.
REQ-007 ENT_N  input  1  count enable T (cascade input), active-low.
REQ-008 UD  input  1  direction: 1 = up, 0 = down.
REQ-009 D  input  WIDTH  parallel load data.
REQ-010 Q  output  WIDTH  registered count value.
REQ-011 RCO_N  output  1  ripple carry out, active-low, combinational (cascade output).

Function
REQ-012 The block SHALL apply the following priority at each rising CLK edge: RST, then load, then count, then hold.
REQ-013 When LD_N=0, the block SHALL set Q to D on the next edge, regardless of ENP_N, ENT_N and UD.
REQ-014 When LD_N=1, ENP_N=0 and ENT_N=0, the block SHALL count one step in the direction given by UD.
REQ-015 When LD_N=1 and either enable is high, the block SHALL hold Q unchanged.
REQ-016 In up-count, the block SHALL set Q+1 if Q < MODULUS-1, otherwise 0; out-of-range values (Q >= MODULUS) therefore wrap to 0 in one step.
REQ-017 In down-count, the block SHALL set MODULUS-1 if Q = 0, otherwise Q-1; out-of-range values decrement normally.
REQ-018 Terminal count (TC) SHALL be defined as Q = MODULUS-1 when UD=1, and Q = 0 when UD=0; it is evaluated on the current Q and UD.
REQ-019 RCO_N SHALL be 0 iff ENT_N=0 and TC=1; ENP_N SHALL NOT affect RCO_N.
REQ-020 RCO_N SHALL follow ENT_N and UD changes combinationally within the same cycle, with no added latency.
REQ-021 Arithmetic SHALL be performed modulo MODULUS on WIDTH bits; no intermediate value SHALL exceed WIDTH+1 bits.
REQ-022 A UD change SHALL take effect on the first edge at which it is sampled; the block SHALL NOT have a direction pipeline.
REQ-023 A load to D = MODULUS-1 with ENT_N=0 SHALL assert RCO_N=0 in the cycle after the load (UD=1).

Reset
REQ-024 RST=1 on a rising edge SHALL set Q to 0, overriding load and count.
REQ-025 RCO_N after reset SHALL be 0 if UD=0 and ENT_N=0; otherwise it SHALL be 1.
REQ-026 A reset asserted mid-count SHALL discard the pending step; counting SHALL resume from 0 on the first edge after RST returns to 0.
REQ-027 The block SHALL have no asynchronous reset path.

Structure
REQ-028 Package pkg_74xx SHALL hold the shared constants: the active-low level values, the UD_UP/UD_DOWN encodings, and a function computing the default MODULUS from WIDTH.
REQ-029 The terminal-count and next-state decode SHALL be a sub-module, mod_74x169_tc, parametrised by WIDTH and MODULUS and purely combinational.
REQ-030 The top level SHALL contain only the Q register, the priority mux, and the RCO_N gate.
REQ-031 Parameter checks SHALL stop elaboration with an error when MODULUS < 2 or MODULUS > 2**WIDTH.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-032 Up wrap: RST, then UD=1, enables low for 12 cycles -> Q runs 0..9,0,1; RCO_N=0 only while Q=9.
REQ-033 Down wrap: load D=2, UD=0, enables low -> Q runs 2,1,0,9,8; RCO_N=0 only while Q=0.
REQ-034 Enable gating: Q=9, UD=1, ENP_N=1, ENT_N=0 -> Q holds 9 and RCO_N=0; then set ENT_N=1 -> RCO_N=1 in the same cycle.
REQ-035 Priority: RST=1 and LD_N=0 with D=5 on the same edge -> Q=0; next edge with LD_N=0 and enables low -> Q=5.
REQ-036 Out-of-range: load D=13, UD=1 -> next Q=0 with no RCO_N pulse; load D=13, UD=0 -> next Q=12.
REQ-037 Cascade: two instances (WIDTH=4, MODULUS=16), RCO_N of the low counter drives ENT_N of the high counter, 256 up-counts from 0 -> combined value wraps 255 -> 0; high RCO_N=0 only at 255.
